// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the tic-tac-toe turn sequencer.
//   - cell encodings stored in the 18-bit board vector (2 bits per cell)
//   - winner codes reported on the winner output
//   - controller state encoding
//   - default board geometry in pixels
//   - helpers to read a cell and to evaluate lines / full board
package game_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    MARK_X = 2'b01,
    MARK_O = 2'b10
  } cell_e;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    WIN_X = 2'b01,
    WIN_O = 2'b10,
    DRAW  = 2'b11
  } winner_e;

  typedef enum logic [2:0] {
    WAIT_PRESS   = 3'd0,
    CHECK        = 3'd1,
    PLACE        = 3'd2,
    EVAL         = 3'd3,
    WAIT_RELEASE = 3'd4,
    OVER         = 3'd5
  } state_e;

  localparam int BOARD_X_DEF   = 262;
  localparam int BOARD_Y_DEF   = 134;
  localparam int CELL_SIZE_DEF = 166;

  // Two-bit contents of cell idx (idx 0..8, row-major).
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    logic [17:0] sh;
    sh = b >> {idx, 1'b0};
    return sh[1:0];
  endfunction

  // Mark owning the line through cells i, j, k, or EMPTY if the line is not complete.
  function automatic logic [1:0] tri_mark(input logic [17:0] b, input int i, input int j,
                                          input int k);
    logic [1:0] a;
    a = b[2*i +: 2];
    if (a != EMPTY && a == b[2*j +: 2] && a == b[2*k +: 2]) return a;
    return EMPTY;
  endfunction

  // First completed line found among rows, columns and diagonals.
  function automatic logic [1:0] line_mark(input logic [17:0] b);
    logic [1:0] m;
    m = tri_mark(b, 0, 1, 2);
    if (m == EMPTY) m = tri_mark(b, 3, 4, 5);
    if (m == EMPTY) m = tri_mark(b, 6, 7, 8);
    if (m == EMPTY) m = tri_mark(b, 0, 3, 6);
    if (m == EMPTY) m = tri_mark(b, 1, 4, 7);
    if (m == EMPTY) m = tri_mark(b, 2, 5, 8);
    if (m == EMPTY) m = tri_mark(b, 0, 4, 8);
    if (m == EMPTY) m = tri_mark(b, 2, 4, 6);
    return m;
  endfunction

  function automatic logic board_full(input logic [17:0] b);
    logic full;
    full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (b[2*i +: 2] == EMPTY) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/cell_locator.sv
// cell_locator: purely combinational mapping of a cursor position onto the
// 3x3 board. Uses absolute pixel thresholds so no subtraction or division is
// needed and positions left/above the board can never wrap into it.
// Ports:
//   xpos_i, ypos_i  cursor position in pixels (12-bit unsigned)
//   row_o, col_o    cell row/column 0..2 (0 when off the board)
//   idx_o           row*3+col
//   in_board_o      cursor lies inside the board in both axes
module cell_locator #(
  parameter int BOARD_X   = 262,
  parameter int BOARD_Y   = 134,
  parameter int CELL_SIZE = 166
) (
  input  logic [11:0] xpos_i,
  input  logic [11:0] ypos_i,
  output logic [1:0]  row_o,
  output logic [1:0]  col_o,
  output logic [3:0]  idx_o,
  output logic        in_board_o
);

  localparam logic [11:0] XB0 = 12'(BOARD_X);
  localparam logic [11:0] XB1 = 12'(BOARD_X + CELL_SIZE);
  localparam logic [11:0] XB2 = 12'(BOARD_X + 2 * CELL_SIZE);
  localparam logic [11:0] XB3 = 12'(BOARD_X + 3 * CELL_SIZE);
  localparam logic [11:0] YB0 = 12'(BOARD_Y);
  localparam logic [11:0] YB1 = 12'(BOARD_Y + CELL_SIZE);
  localparam logic [11:0] YB2 = 12'(BOARD_Y + 2 * CELL_SIZE);
  localparam logic [11:0] YB3 = 12'(BOARD_Y + 3 * CELL_SIZE);

  logic xOk;
  logic yOk;

  always_comb begin
    col_o = 2'd0;
    xOk   = 1'b1;
    if (xpos_i < XB0)      xOk   = 1'b0;
    else if (xpos_i < XB1) col_o = 2'd0;
    else if (xpos_i < XB2) col_o = 2'd1;
    else if (xpos_i < XB3) col_o = 2'd2;
    else                   xOk   = 1'b0;

    row_o = 2'd0;
    yOk   = 1'b1;
    if (ypos_i < YB0)      yOk   = 1'b0;
    else if (ypos_i < YB1) row_o = 2'd0;
    else if (ypos_i < YB2) row_o = 2'd1;
    else if (ypos_i < YB3) row_o = 2'd2;
    else                   yOk   = 1'b0;

    // Off-board positions report cell 0 so downstream never sees a bogus index.
    if (!(xOk && yOk)) begin
      row_o = 2'd0;
      col_o = 2'd0;
    end
    in_board_o = xOk & yOk;
    idx_o      = 4'({row_o, 1'b0}) + 4'(row_o) + 4'(col_o);
  end

endmodule

// File: rtl/game_ctl.sv
// game_ctl: turn sequencer and board-state owner for the tic-tac-toe display.
// Decodes mouse clicks into cells, keeps the board, alternates players,
// detects win/draw, and publishes a highlight position that only moves at the
// start of vertical blanking so the draw stages never tear.
// Ports:
//   pclk, rst            pixel clock, synchronous active-high reset
//   mouse_xpos/ypos      cursor position (pixels)
//   mouse_left           left button level (pclk-synchronous)
//   new_game             level, restarts the game (priority over clicks)
//   vblnk_in             vertical blank from the timing chain
//   board                cell i at [2i+1:2i], 00 empty / 01 X / 10 O
//   player               side to move, 0 = X, 1 = O
//   winner, game_over    00 none / 01 X / 10 O / 11 draw; game_over = winner != 0
//   hl_xpos/ypos/valid   highlighted cell origin and draw enable
module game_ctl
  import game_pkg::*;
#(
  parameter int BOARD_X   = BOARD_X_DEF,
  parameter int BOARD_Y   = BOARD_Y_DEF,
  parameter int CELL_SIZE = CELL_SIZE_DEF
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  input  logic        new_game,
  input  logic        vblnk_in,
  output logic [17:0] board,
  output logic        player,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic [11:0] hl_xpos,
  output logic [11:0] hl_ypos,
  output logic        hl_valid
);

  localparam logic [11:0] XB0 = 12'(BOARD_X);
  localparam logic [11:0] XB1 = 12'(BOARD_X + CELL_SIZE);
  localparam logic [11:0] XB2 = 12'(BOARD_X + 2 * CELL_SIZE);
  localparam logic [11:0] YB0 = 12'(BOARD_Y);
  localparam logic [11:0] YB1 = 12'(BOARD_Y + CELL_SIZE);
  localparam logic [11:0] YB2 = 12'(BOARD_Y + 2 * CELL_SIZE);

  state_e      state_q,  state_d;
  logic [17:0] board_q,  board_d;
  logic        player_q, player_d;
  logic [1:0]  winner_q, winner_d;
  logic        over_q,   over_d;
  logic        ml_q,     ml_d;
  logic        vb_q,     vb_d;
  logic [3:0]  idx_q,    idx_d;
  logic        inb_q,    inb_d;
  logic [11:0] hlx_q,    hlx_d;
  logic [11:0] hly_q,    hly_d;
  logic        hlv_q,    hlv_d;

  logic [1:0]  locRow;
  logic [1:0]  locCol;
  logic [3:0]  locIdx;
  logic        locIn;
  logic        press;
  logic [1:0]  lineMark;

  // One locator serves both the click path and the highlight path: both
  // look at the live cursor position.
  cell_locator #(
    .BOARD_X   (BOARD_X),
    .BOARD_Y   (BOARD_Y),
    .CELL_SIZE (CELL_SIZE)
  ) u_locator (
    .xpos_i     (mouse_xpos),
    .ypos_i     (mouse_ypos),
    .row_o      (locRow),
    .col_o      (locCol),
    .idx_o      (locIdx),
    .in_board_o (locIn)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= WAIT_PRESS;
      board_q  <= '0;
      player_q <= 1'b0;
      winner_q <= NONE;
      over_q   <= 1'b0;
      ml_q     <= 1'b0;
      vb_q     <= 1'b0;
      idx_q    <= '0;
      inb_q    <= 1'b0;
      hlx_q    <= '0;
      hly_q    <= '0;
      hlv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      player_q <= player_d;
      winner_q <= winner_d;
      over_q   <= over_d;
      ml_q     <= ml_d;
      vb_q     <= vb_d;
      idx_q    <= idx_d;
      inb_q    <= inb_d;
      hlx_q    <= hlx_d;
      hly_q    <= hly_d;
      hlv_q    <= hlv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    player_d = player_q;
    winner_d = winner_q;
    idx_d    = idx_q;
    inb_d    = inb_q;
    hlx_d    = hlx_q;
    hly_d    = hly_q;
    hlv_d    = hlv_q;
    ml_d     = mouse_left;
    vb_d     = vblnk_in;
    press    = mouse_left & ~ml_q;
    lineMark = line_mark(board_q);

    // Highlight is sampled only on the blanking rise so it is stable all frame.
    if (vblnk_in && !vb_q) begin
      case (locCol)
        2'd0:    hlx_d = XB0;
        2'd1:    hlx_d = XB1;
        default: hlx_d = XB2;
      endcase
      case (locRow)
        2'd0:    hly_d = YB0;
        2'd1:    hly_d = YB1;
        default: hly_d = YB2;
      endcase
      hlv_d = locIn && (cell_at(board_q, locIdx) == EMPTY) && !over_q;
    end

    case (state_q)
      WAIT_PRESS: begin
        if (press) begin
          idx_d   = locIdx;
          inb_d   = locIn;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (inb_q && cell_at(board_q, idx_q) == EMPTY) state_d = PLACE;
        else                                           state_d = WAIT_RELEASE;
      end
      PLACE: begin
        for (int i = 0; i < 9; i++) begin
          if (idx_q == 4'(i)) board_d[2*i +: 2] = player_q ? MARK_O : MARK_X;
        end
        state_d = EVAL;
      end
      EVAL: begin
        if (lineMark != EMPTY) begin
          winner_d = lineMark;
          state_d  = OVER;
        end else if (board_full(board_q)) begin
          winner_d = DRAW;
          state_d  = OVER;
        end else begin
          player_d = ~player_q;
          state_d  = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!mouse_left) state_d = WAIT_PRESS;
      end
      OVER: begin
        state_d = OVER;
      end
      default: state_d = WAIT_PRESS;
    endcase

    // A restart with the button still down waits for release, otherwise the
    // cleared ml_q would turn the held button into a fresh press.
    if (new_game) begin
      board_d  = '0;
      player_d = 1'b0;
      winner_d = NONE;
      idx_d    = '0;
      inb_d    = 1'b0;
      hlx_d    = '0;
      hly_d    = '0;
      hlv_d    = 1'b0;
      ml_d     = 1'b0;
      vb_d     = 1'b0;
      state_d  = mouse_left ? WAIT_RELEASE : WAIT_PRESS;
    end

    over_d = (winner_d != NONE);
  end

  assign board     = board_q;
  assign player    = player_q;
  assign winner    = winner_q;
  assign game_over = over_q;
  assign hl_xpos   = hlx_q;
  assign hl_ypos   = hly_q;
  assign hl_valid  = hlv_q;

endmodule

// File: doc/game_ctl.md
# game_ctl

Turn sequencer and board-state owner for the tic-tac-toe display pipeline. It decodes mouse clicks into board cells, keeps the 3x3 board, alternates players, and detects win or draw. It also gives the rectangle/marker drawing stages a tear-free highlight position that is updated only at the start of vertical blanking. It sits between the mouse interface and the draw stages, in the pclk domain.

## Interface
Parameters:
- BOARD_X, 262: left edge of board, pixels.
- BOARD_Y, 134: top edge of board, pixels.
- CELL_SIZE, 166: cell edge length, pixels (board spans 3*CELL_SIZE).

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mouse_xpos  in  12  cursor x, pixels.
- mouse_ypos  in  12  cursor y, pixels.
- mouse_left  in  1  left button level, already synchronous to pclk.
- new_game  in  1  level; restarts the game.
- vblnk_in  in  1  vertical blank from the timing chain.
- board  out  18  cell i at bits [2i+1:2i]; i = row*3+col; 00 empty, 01 X, 10 O.
- player  out  1  side to move; 0 = X, 1 = O.
- winner  out  2  00 none, 01 X, 10 O, 11 draw.
- game_over  out  1  winner != 00.
- hl_xpos  out  12  left pixel of highlighted cell.
- hl_ypos  out  12  top pixel of highlighted cell.
- hl_valid  out  1  highlight should be drawn.

## Operation
- Reset (and new_game) drive these values: board=0, player=0, winner=00, game_over=0, hl_xpos=0, hl_ypos=0, hl_valid=0, state=WAIT_PRESS, ml_q=0, vb_q=0.
- Cell locate:
  - Comparisons only, no divider.
  - col = 0/1/2 when x−BOARD_X is in [0,CS), [CS,2CS), [2CS,3CS).
  - row is derived the same way from y.
  - in_board=0 when the cursor is outside the board in either axis.
  - idx = row*3+col, 4 bits.
- Press edge: press = mouse_left & ~ml_q, where ml_q is the registered mouse_left.
- State machine:
  - WAIT_PRESS: on press, latch idx and in_board, then go to CHECK.
  - CHECK: if in_board and board[idx]==00, go to PLACE; otherwise go to WAIT_RELEASE with no change.
  - PLACE: write board[idx] = player ? 10 : 01, then go to EVAL.
  - EVAL: test the 3 rows, 3 columns and 2 diagonals of the registered board.
    - On a line match, winner = that mark, then go to OVER.
    - Else if all 9 cells are non-zero, winner=11, then go to OVER.
    - Else toggle player, then go to WAIT_RELEASE.
  - WAIT_RELEASE: when mouse_left==0, go to WAIT_PRESS.
  - OVER: hold board, winner and player; ignore clicks; leave only on new_game.
- new_game:
  - Acts in every state and has priority over press.
  - Next cycle all outputs hold their reset values and state=WAIT_PRESS.
  - If the button is still held, the bench must release it before a new press registers (ml_q is reset to 0, so a held button reads as a press; the implementation forces state to WAIT_RELEASE instead when mouse_left==1 at new_game).
- Highlight update:
  - Happens only on the vblnk_in rising edge (vblnk_in & ~vb_q).
  - hl_xpos = BOARD_X + col*CS and hl_ypos = BOARD_Y + row*CS of the current cursor.
  - hl_valid = in_board & cell empty & ~game_over.
  - Between edges the highlight outputs are held.
- Arithmetic:
  - Unsigned 12-bit.
  - x<BOARD_X means out of board; there is no wrap of the subtraction (compare before subtracting).

## Timing
- Press sampled at cycle N: CHECK at N+1, board written at N+2 (visible at N+3).
- EVAL at N+3. winner, game_over and player are updated at the end of N+3 (visible at N+4).
- A press during CHECK, PLACE, EVAL, WAIT_RELEASE or OVER is ignored.
- One move per press; holding the button never places twice.
- The highlight changes at most once per frame, one cycle after the vblnk_in rise.
- All outputs are registered; no combinational paths from input to output.

## Structure
- Package game_pkg holds:
  - cell encodings (EMPTY, MARK_X, MARK_O);
  - winner codes (NONE, WIN_X, WIN_O, DRAW);
  - state encoding (WAIT_PRESS, CHECK, PLACE, EVAL, WAIT_RELEASE, OVER);
  - default board geometry constants.
- Sub-module cell_locator: combinational mapping of (x, y) to (row, col, idx, in_board), parameterised by BOARD_X, BOARD_Y and CELL_SIZE. It is shared by the press path and the highlight path.

## Test plan
- Click centre: cursor (428,300), press → board = 18'h00100 (cell 4 = 01) at N+3, player=1 at N+4.
- Occupied cell: after the X at cell 4, O clicks (428,300) → board unchanged, player stays 1.
- Row win: X plays cells 0, 1, 2 with O on 3 and 4 → winner=01 and game_over=1 after the X at 2. Further clicks leave board unchanged.
- Draw: the sequence X0 O1 X2 O4 X3 O5 X7 O6 X8 → winner=11 after the last move, no line match.
- Out of board: press at (10,10) → no board change, state returns to WAIT_PRESS after release. Highlight: hl_valid=0 after the next vblnk rise.
- new_game asserted during EVAL of a winning move → next cycle board=0, winner=00, player=0. Holding mouse_left places nothing until it is released and pressed again.
